alu_sequencer: RTL and testbench

//  Issue-side controller for the 16-bit ALU. Accepts one decoded op at a time, registers aluMode/op, and lets

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Decode-side handshake and retire status for the ALU sequencer.
//   master : decode stage (drives issue_*, observes issue_ready and retire_*)
//   slave  : alu_sequencer (accepts issue_*, drives issue_ready and retire_*)
interface alu_seq_if;
    logic       issue_valid;
    logic       issue_ready;
    logic       issue_alu_mode;
    logic [2:0] issue_op;
    logic       retire_valid;
    logic       retire_branch;
    logic       retire_wb;
    logic       retire_illegal;
    logic       retire_timeout;

    modport master (
        output issue_valid, issue_alu_mode, issue_op,
        input  issue_ready,
        input  retire_valid, retire_branch, retire_wb, retire_illegal, retire_timeout
    );

    modport slave (
        input  issue_valid, issue_alu_mode, issue_op,
        output issue_ready,
        output retire_valid, retire_branch, retire_wb, retire_illegal, retire_timeout
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issue-side controller for the 16-bit ALU: accepts one decoded op, lets
//   operands settle for a cycle, holds execute until the ALU reports done or
//   branch, re-arms the ALU with a reset strobe and retires the op with a
//   one-cycle status pulse. Illegal ops bypass the ALU; a hung ALU is retired
//   with a timeout flag.
// Ports
//   clk, rst_n            clock, async active-low reset
//   seq (slave)           issue handshake and retire status
//   alu_mode, alu_op      latched op driven to the ALU
//   alu_execute           execute strobe
//   alu_reset             resetALU strobe
//   alu_done, alu_branch  ALU executeComplete / branchExecute
//   busy                  high whenever not idle
//
// state  | meaning
// INIT   | one-cycle ALU reset pulse after reset release
// IDLE   | ready to accept an op
// SETUP  | operands settle, execute low
// WAIT   | execute high, waiting for done/branch or timeout
// CLEAR  | resetALU high until status drops or timeout
// RETIRE | retire_valid pulse with latched flags
module alu_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   seq,
    output logic       alu_mode,
    output logic [2:0] alu_op,
    output logic       alu_execute,
    output logic       alu_reset,
    input  logic       alu_done,
    input  logic       alu_branch,
    output logic       busy
);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;
    localparam logic [2:0] ST_RETIRE = 3'd5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             mode_q, mode_d;
    logic [2:0]       op_q, op_d;
    logic             branch_q, branch_d;
    logic             timeout_q, timeout_d;
    logic             illegal_q, illegal_d;

    logic ready_q, ready_d;
    logic execute_q, execute_d;
    logic reset_q, reset_d;
    logic busy_q, busy_d;
    logic rv_q, rv_d;
    logic rb_q, rb_d;
    logic rwb_q, rwb_d;
    logic ril_q, ril_d;
    logic rto_q, rto_d;

    logic accept, illegal_op;

    assign accept     = seq.issue_valid && ready_q;
    assign illegal_op = !seq.issue_alu_mode && (seq.issue_op >= 3'd3);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        op_d      = op_q;
        branch_d  = branch_q;
        timeout_d = timeout_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_INIT: begin
                // Leave only once the reset pulse has actually been driven.
                if (reset_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    mode_d    = seq.issue_alu_mode;
                    op_d      = seq.issue_op;
                    branch_d  = 1'b0;
                    timeout_d = 1'b0;
                    illegal_d = illegal_op;
                    cnt_d     = '0;
                    state_d   = illegal_op ? ST_RETIRE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_branch) begin
                    // Only conditional branches may report a taken branch.
                    branch_d = !mode_q && ((op_q == 3'd1) || (op_q == 3'd2));
                    cnt_d    = '0;
                    state_d  = ST_CLEAR;
                end else if (alu_done) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_CLEAR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_CLEAR: begin
                if (!alu_done && !alu_branch) begin
                    state_d = ST_RETIRE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RETIRE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        execute_d = (state_d == ST_WAIT);
        reset_d   = (state_d == ST_INIT) || (state_d == ST_CLEAR);
        busy_d    = (state_d != ST_IDLE);
        rv_d      = (state_d == ST_RETIRE);
        rb_d      = rv_d && branch_d;
        ril_d     = rv_d && illegal_d;
        rto_d     = rv_d && timeout_d;
        rwb_d     = rv_d && !timeout_d && !illegal_d && (mode_d || (op_d == 3'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            op_q      <= 3'd0;
            branch_q  <= 1'b0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b0;
            execute_q <= 1'b0;
            reset_q   <= 1'b0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            rb_q      <= 1'b0;
            rwb_q     <= 1'b0;
            ril_q     <= 1'b0;
            rto_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            op_q      <= op_d;
            branch_q  <= branch_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
            execute_q <= execute_d;
            reset_q   <= reset_d;
            busy_q    <= busy_d;
            rv_q      <= rv_d;
            rb_q      <= rb_d;
            rwb_q     <= rwb_d;
            ril_q     <= ril_d;
            rto_q     <= rto_d;
        end
    end

    assign seq.issue_ready    = ready_q;
    assign seq.retire_valid   = rv_q;
    assign seq.retire_branch  = rb_q;
    assign seq.retire_wb      = rwb_q;
    assign seq.retire_illegal = ril_q;
    assign seq.retire_timeout = rto_q;
    assign alu_mode           = mode_q;
    assign alu_op             = op_q;
    assign alu_execute        = execute_q;
    assign alu_reset          = reset_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_mode;
    logic [2:0] alu_op;
    logic       alu_execute;
    logic       alu_reset;
    logic       alu_done = 1'b0;
    logic       alu_branch = 1'b0;
    logic       busy;

    alu_seq_if seq ();

    alu_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .seq(seq),
        .alu_mode(alu_mode), .alu_op(alu_op),
        .alu_execute(alu_execute), .alu_reset(alu_reset),
        .alu_done(alu_done), .alu_branch(alu_branch), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [2:0] op;
        logic       branch;
        logic       wb;
        logic       illegal;
        logic       timeout;
        int         exec_n;
        int         reset_n;
        int         retire_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_retire = -1;

    // ALU model configuration, written only by the stimulus process.
    logic m_en = 1'b0;
    int   m_kind = 0;       // 0 done, 1 branch, 2 both
    int   m_delay = 0;
    int   m_hold = 0;
    logic m_spur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural ALU: answers after m_delay execute cycles and keeps the
    // status up for m_hold cycles after execute falls.
    initial begin : alu_model
        int  ecount;
        int  hold_left;
        logic resp;
        ecount = 0; hold_left = 0; resp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp = 1'b0;
                ecount = 0;
            end else if (alu_execute) begin
                ecount++;
                if (m_en && ecount > m_delay) begin
                    resp = 1'b1;
                    hold_left = m_hold;
                end
            end else begin
                ecount = 0;
                if (resp) begin
                    if (hold_left > 0) hold_left--;
                    else resp = 1'b0;
                end
            end
            alu_done   = (resp && m_kind != 1) || m_spur;
            alu_branch = resp && m_kind != 0;
        end
    end

    // Monitor: pops an expectation on every retire pulse.
    initial begin : monitor
        exp_t e;
        int   exec_cnt;
        int   rst_cnt;
        exec_cnt = 0; rst_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || seq.issue_ready) begin
                exec_cnt = 0;
                rst_cnt = 0;
            end else begin
                if (alu_execute) exec_cnt++;
                if (alu_reset) rst_cnt++;
            end
            if (seq.retire_valid) begin
                last_retire = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("retire_branch", seq.retire_branch, e.branch);
                    chk("retire_wb", seq.retire_wb, e.wb);
                    chk("retire_illegal", seq.retire_illegal, e.illegal);
                    chk("retire_timeout", seq.retire_timeout, e.timeout);
                    chk("alu_mode", alu_mode, e.mode);
                    chk("alu_op", alu_op, e.op);
                    chk("exec_cycles", exec_cnt, e.exec_n);
                    chk("reset_cycles", rst_cnt, e.reset_n);
                    chk("retire_cycle", cyc, e.retire_cyc);
                end
            end else begin
                chk("retire_flags_idle",
                    {seq.retire_branch, seq.retire_wb, seq.retire_illegal, seq.retire_timeout}, 0);
            end
        end
    end

    // Issue one op; ALU behaviour and expected outcome derived from plain rules.
    task automatic issue(input logic mode, input logic [2:0] op, input int kind,
                         input int delay, input int hold, input logic silent, output int acc);
        exp_t e;
        int   w;
        int   wait_n;
        int   clear_n;
        w = 0;
        while (!(seq.issue_ready && !alu_done && !alu_branch) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) chk("ready_wait_expired", 0, 1);
        m_en = !silent; m_kind = kind; m_delay = delay; m_hold = hold;
        acc = cyc + 1;
        e.mode = mode;
        e.op = op;
        e.illegal = !mode && op >= 3'd3;
        if (e.illegal) begin
            e.branch = 1'b0; e.timeout = 1'b0; e.wb = 1'b0;
            e.exec_n = 0; e.reset_n = 0; e.retire_cyc = acc;
        end else begin
            e.timeout = silent || hold >= TO;
            e.branch = !silent && kind != 0 && !mode && (op == 3'd1 || op == 3'd2);
            e.wb = !e.timeout && (mode || op == 3'd0);
            wait_n = silent ? TO : delay + 1;
            clear_n = silent ? 1 : ((hold >= TO) ? TO : hold + 1);
            e.exec_n = wait_n;
            e.reset_n = clear_n;
            e.retire_cyc = acc + 1 + wait_n + clear_n;
        end
        sb.push_back(e);
        seq.issue_valid = 1'b1;
        seq.issue_alu_mode = mode;
        seq.issue_op = op;
        @(negedge clk);
        seq.issue_valid = 1'b0;
        seq.issue_alu_mode = 1'($urandom);
        seq.issue_op = 3'($urandom);
        chk("ready_drop_after_accept", seq.issue_ready, 0);
    endtask

    initial begin : stim
        int acc;
        int w;
        seq.issue_valid = 1'b0;
        seq.issue_alu_mode = 1'b0;
        seq.issue_op = 3'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_issue_ready", seq.issue_ready, 0);
        chk("rst_execute", alu_execute, 0);
        chk("rst_alu_reset", alu_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_retire_valid", seq.retire_valid, 0);
        chk("rst_mode_op", {alu_mode, alu_op}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_alu_reset", alu_reset, 1);
        chk("init_ready", seq.issue_ready, 0);
        @(negedge clk);
        chk("idle_alu_reset", alu_reset, 0);
        chk("idle_ready", seq.issue_ready, 1);
        chk("idle_busy", busy, 0);

        issue(1'b1, 3'd0, 0, 0, 0, 1'b0, acc);     // ADD, 4-cycle op
        issue(1'b0, 3'd1, 2, 0, 0, 1'b0, acc);     // BEQ taken, done+branch together
        issue(1'b0, 3'd2, 0, 0, 0, 1'b0, acc);     // BNE not taken
        issue(1'b1, 3'd4, 0, 0, 0, 1'b0, acc);     // back-to-back
        chk("b2b_accept_gap", acc, last_retire + 2);
        issue(1'b0, 3'd5, 0, 0, 0, 1'b0, acc);     // illegal

        for (int i = 0; i < 60; i++) begin
            int r;
            int hold;
            r = int'($urandom % 10);
            hold = (r == 0) ? 20 : ((r < 5) ? 0 : r - 5);
            issue(1'($urandom), 3'($urandom), int'($urandom % 3), int'($urandom % 6),
                  hold, ($urandom % 12) == 0, acc);
        end

        issue(1'b1, 3'd3, 0, 0, 0, 1'b1, acc);     // silent ALU

        // Reset in the middle of WAIT: op is dropped, no retire.
        issue(1'b1, 3'd1, 0, 0, 0, 1'b1, acc);
        w = 0;
        while (!alu_execute && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("reach_wait", alu_execute, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_execute", alu_execute, 0);
        chk("async_rst_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rearm_alu_reset", alu_reset, 1);
        chk("rearm_ready", seq.issue_ready, 0);
        @(negedge clk);
        chk("rearm_done_reset", alu_reset, 0);
        chk("rearm_ready_up", seq.issue_ready, 1);

        // Spurious status in IDLE is ignored.
        m_spur = 1'b1;
        @(negedge clk);
        m_spur = 1'b0;
        @(negedge clk);
        chk("spurious_ready", seq.issue_ready, 1);
        chk("spurious_busy", busy, 0);
        issue(1'b1, 3'd7, 1, 2, 1, 1'b0, acc);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
